line_buffer: RTL and testbench
==============================

LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 SHALL have parameter NLINES, default 2: number of line slots.
REQ-002 SHALL have parameter NBEATS, default 8: beats per line.
REQ-003 SHALL have parameter DATA_W, default 64: beat width.
REQ-004 SHALL have parameter type T, default LineBufferReadReqST: read-request struct.
REQ-005 SHALL have port clock, input, 1: the only clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low.
REQ-007 SHALL have port io_alloc_valid, input, 1: clear slot io_alloc_line for a new refill.
REQ-008 SHALL have port io_alloc_line, input, log2(NLINES): slot to allocate.
REQ-009 SHALL have port io_refill_valid, input, 1: refill beat present.
REQ-010 SHALL have port io_refill_ready, output, 1: refill beat accepted.
REQ-011 SHALL have port io_refill_line, input, log2(NLINES): destination slot.
REQ-012 SHALL have port io_refill_data, input, DATA_W: beat data.
REQ-013 SHALL have port io_refill_done, output, 1: one-cycle pulse when a slot's last beat is written.
REQ-014 SHALL have port io_req_valid, input, 1: read request from the upstream arbiter output.
REQ-015 SHALL have port io_req_ready, output, 1: read request accepted.
REQ-016 SHALL have port io_req, input, T: request carrying fields line and beat.
REQ-017 SHALL have port io_resp_valid, output, 1: read data valid.
REQ-018 SHALL have port io_resp_ready, input, 1: consumer accepts read data.
REQ-019 SHALL have port io_resp_data, output, DATA_W: read data.

Function
REQ-020 SHALL hold storage of NLINES x NBEATS x DATA_W, one beat-valid bit per beat, and a per-slot beat counter of log2(NBEATS) bits.
REQ-021 SHALL set io_refill_ready=1, except 0 when io_alloc_valid=1 and io_alloc_line==io_refill_line.
REQ-022 SHALL, on refill handshake, write data at beat = counter of io_refill_line, set that beat-valid bit, and increment the counter.
REQ-023 SHALL, when the counter is NBEATS-1 at the handshake, wrap the counter to 0 and pulse io_refill_done the next cycle.
REQ-024 SHALL, on io_alloc_valid, clear all beat-valid bits and the counter of io_alloc_line in the next cycle; other slots are unaffected.
REQ-025 SHALL set io_req_ready = beat_valid[io_req.line][io_req.beat] AND (output register empty OR io_resp_ready).
REQ-026 SHALL set io_req_ready=0 for a request targeting a beat being written or a slot being allocated in the same cycle, with no same-cycle bypass.
REQ-027 SHALL, on request handshake, load the output register so io_resp_valid=1 and io_resp_data=stored beat in the next cycle: 1-cycle latency.
REQ-028 SHALL hold io_resp_valid and io_resp_data stable while io_resp_ready=0.
REQ-029 SHALL clear the output register on response handshake unless a new request is accepted in the same cycle, which sustains 1 response per cycle.
REQ-030 SHALL not require requests to be in order; any valid beat of any slot is readable.
REQ-031 SHALL not issue a response for a request that was never accepted; an unaccepted request stalls indefinitely until its beat becomes valid.

Reset
REQ-032 SHALL, on reset low at a clock edge, clear all beat-valid bits, counters, and the output register.
REQ-033 SHALL drive io_resp_valid=0, io_req_ready=0, io_refill_ready=0, io_refill_done=0 while reset is low.
REQ-034 SHALL not initialise data storage on reset.
REQ-035 SHALL, on reset mid-refill or mid-response, abandon the refill or response with no pulse or response after reset release.

Structure
REQ-036 SHALL have LineBufferReadReqST {line, beat} and constants NLINES, NBEATS, and DATA_W defined in package BoomLSUST.
REQ-037 SHALL be implemented as one sub-module, lb_resp_reg: a single-entry valid/ready output register holding the response.

Verification
REQ-038 SHALL cover: alloc slot 0, 8 refill beats 0x10..0x17 -> io_refill_done pulses 1 cycle after the 8th beat, counter is 0.
REQ-039 SHALL cover: read slot 0 beat 3 after the refill -> io_req_ready=1, next cycle io_resp_valid=1, io_resp_data=0x13.
REQ-040 SHALL cover: read slot 1 beat 5 before it is written -> io_req_ready=0 until the beat-5 refill cycle has passed, then data returned.
REQ-041 SHALL cover: io_resp_ready=0 for 4 cycles with a second request pending -> io_resp_data stable, second request not accepted; then back-to-back responses.
REQ-042 SHALL cover: alloc and refill to the same slot in the same cycle -> io_refill_ready=0; the beat is written the following cycle as beat 0.
REQ-043 SHALL cover: reset asserted while io_resp_valid=1 -> io_resp_valid=0 on the next edge; a read of a previously valid beat stalls after release.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// Shared types and default geometry for the LSU line buffer.
package BoomLSUST;

    localparam int NLINES = 2;
    localparam int NBEATS = 8;
    localparam int DATA_W = 64;

    localparam int LINE_W = (NLINES > 1) ? $clog2(NLINES) : 1;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    // Read request: which slot and which beat within it.
    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [BEAT_W-1:0] beat;
    } LineBufferReadReqST;

endpackage

// File: rtl/line_buffer_resp_reg.sv
// Single-entry valid/ready holding register for read responses.
// Accepts a new entry when empty or when the current one is leaving.
module lb_resp_reg #(
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    logic              valid_q;
    logic              valid_d;
    logic              load;
    logic [DATA_W-1:0] data_q;

    // Next-state: a load wins, otherwise the entry drains on handshake.
    always_comb begin
        in_ready_o = !valid_q || out_ready_i;
        load       = in_valid_i && in_ready_o;
        valid_d    = load || (valid_q && !out_ready_i);
    end

    // Occupancy flag, cleared by synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload only changes on load, so it stays stable while stalled.
    always_ff @(posedge clock) begin
        if (load) begin
            data_q <= in_data_i;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/line_buffer.sv
// Line buffer: refill beats stream into per-slot storage, and any beat that
// has landed can be read back out of order through a 1-deep response register.
module line_buffer
    import BoomLSUST::LineBufferReadReqST;
#(
    parameter int  NLINES = BoomLSUST::NLINES,
    parameter int  NBEATS = BoomLSUST::NBEATS,
    parameter int  DATA_W = BoomLSUST::DATA_W,
    parameter type T      = LineBufferReadReqST,
    localparam int LW     = (NLINES > 1) ? $clog2(NLINES) : 1,
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_alloc_valid,
    input  logic [LW-1:0]     io_alloc_line,
    input  logic              io_refill_valid,
    output logic              io_refill_ready,
    input  logic [LW-1:0]     io_refill_line,
    input  logic [DATA_W-1:0] io_refill_data,
    output logic              io_refill_done,
    input  logic              io_req_valid,
    output logic              io_req_ready,
    input  T                  io_req,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [DATA_W-1:0] io_resp_data
);

    logic [NBEATS-1:0] bv_q  [NLINES];
    logic [BW-1:0]     cnt_q [NLINES];
    logic [DATA_W-1:0] mem_q [NLINES][NBEATS];
    logic              done_q;
    logic              done_d;

    logic              refill_hs;
    logic [BW-1:0]     wr_beat;
    logic              wr_last;
    logic              req_ok;
    logic              rr_in_ready;
    logic              rr_valid;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rr_data;

    // Refill acceptance: a slot being cleared this cycle refuses its beat.
    always_comb begin
        io_refill_ready = reset && !(io_alloc_valid && (io_alloc_line == io_refill_line));
        refill_hs       = io_refill_valid && io_refill_ready;
        wr_beat         = cnt_q[io_refill_line];
        wr_last         = (wr_beat == BW'(NBEATS - 1));
        done_d          = refill_hs && wr_last;
    end

    // Read gating: beat must be valid and not being rewritten or cleared now.
    always_comb begin
        req_ok = reset && bv_q[io_req.line][io_req.beat];
        if (refill_hs && (io_refill_line == io_req.line) && (wr_beat == io_req.beat)) begin
            req_ok = 1'b0;
        end
        if (io_alloc_valid && (io_alloc_line == io_req.line)) begin
            req_ok = 1'b0;
        end
        io_req_ready = req_ok && rr_in_ready;
        rd_data      = mem_q[io_req.line][io_req.beat];
    end

    // Beat-valid bits, fill counters and the done pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int l = 0; l < NLINES; l++) begin
                bv_q[l]  <= '0;
                cnt_q[l] <= '0;
            end
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (refill_hs) begin
                bv_q[io_refill_line][wr_beat] <= 1'b1;
                cnt_q[io_refill_line]         <= wr_last ? '0 : wr_beat + 1'b1;
            end
            if (io_alloc_valid) begin
                bv_q[io_alloc_line]  <= '0;
                cnt_q[io_alloc_line] <= '0;
            end
        end
    end

    // Beat storage is never reset; beat-valid bits guard every read.
    always_ff @(posedge clock) begin
        if (refill_hs) begin
            mem_q[io_refill_line][wr_beat] <= io_refill_data;
        end
    end

    lb_resp_reg #(
        .DATA_W (DATA_W)
    ) u_resp (
        .clock       (clock),
        .reset       (reset),
        .in_valid_i  (io_req_valid && req_ok),
        .in_ready_o  (rr_in_ready),
        .in_data_i   (rd_data),
        .out_valid_o (rr_valid),
        .out_ready_i (io_resp_ready),
        .out_data_o  (rr_data)
    );

    assign io_refill_done = done_q && reset;
    assign io_resp_valid  = rr_valid && reset;
    assign io_resp_data   = rr_data;

endmodule

// File: tb/tb_line_buffer.sv
// Scoreboard bench for line_buffer: a negedge monitor tracks expected state
// and response data; directed scenarios add targeted checks.
module tb_line_buffer;
    import BoomLSUST::*;

    localparam int NL = 2;
    localparam int NB = 8;
    localparam int DW = 64;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               io_alloc_valid = 1'b0;
    logic [0:0]         io_alloc_line = '0;
    logic               io_refill_valid = 1'b0;
    logic               io_refill_ready;
    logic [0:0]         io_refill_line = '0;
    logic [DW-1:0]      io_refill_data = '0;
    logic               io_refill_done;
    logic               io_req_valid = 1'b0;
    logic               io_req_ready;
    LineBufferReadReqST io_req = '0;
    logic               io_resp_valid;
    logic               io_resp_ready = 1'b1;
    logic [DW-1:0]      io_resp_data;

    line_buffer #(
        .NLINES (NL),
        .NBEATS (NB),
        .DATA_W (DW),
        .T      (LineBufferReadReqST)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .io_alloc_valid  (io_alloc_valid),
        .io_alloc_line   (io_alloc_line),
        .io_refill_valid (io_refill_valid),
        .io_refill_ready (io_refill_ready),
        .io_refill_line  (io_refill_line),
        .io_refill_data  (io_refill_data),
        .io_refill_done  (io_refill_done),
        .io_req_valid    (io_req_valid),
        .io_req_ready    (io_req_ready),
        .io_req          (io_req),
        .io_resp_valid   (io_resp_valid),
        .io_resp_ready   (io_resp_ready),
        .io_resp_data    (io_resp_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model state, advanced once per cycle at the falling edge.
    logic [NB-1:0] m_bv  [NL];
    int            m_cnt [NL];
    logic [63:0]   m_mem [NL][NB];
    logic          m_ov;
    logic          m_done;
    logic [63:0]   m_q [$];

    always @(negedge clock) begin
        logic exp_rr, exp_qr, rhs, qhs;
        int   rl, rb, ql, qb;
        if (!reset) begin
            check("rst_resp_valid", io_resp_valid, 0);
            check("rst_req_ready", io_req_ready, 0);
            check("rst_refill_ready", io_refill_ready, 0);
            check("rst_refill_done", io_refill_done, 0);
            for (int l = 0; l < NL; l++) begin
                m_bv[l]  = '0;
                m_cnt[l] = 0;
            end
            m_ov   = 1'b0;
            m_done = 1'b0;
            m_q.delete();
        end else begin
            rl     = int'(io_refill_line);
            rb     = m_cnt[rl];
            ql     = int'(io_req.line);
            qb     = int'(io_req.beat);
            exp_rr = !(io_alloc_valid && (io_alloc_line == io_refill_line));
            rhs    = io_refill_valid && exp_rr;
            exp_qr = m_bv[ql][qb] && (!m_ov || io_resp_ready)
                     && !(rhs && rl == ql && rb == qb)
                     && !(io_alloc_valid && int'(io_alloc_line) == ql);
            check("refill_ready", io_refill_ready, exp_rr);
            check("refill_done", io_refill_done, m_done);
            check("resp_valid", io_resp_valid, m_ov);
            if (io_req_valid) check("req_ready", io_req_ready, exp_qr);
            qhs = io_req_valid && exp_qr;
            if (m_ov) begin
                if (m_q.size() == 0) check("sb_underflow", 1, 0);
                else check("resp_data", io_resp_data, m_q[0]);
                if (io_resp_ready) begin
                    if (m_q.size() > 0) void'(m_q.pop_front());
                    m_ov = 1'b0;
                end
            end
            if (qhs) begin
                m_q.push_back(m_mem[ql][qb]);
                m_ov = 1'b1;
            end
            m_done = rhs && (rb == NB - 1);
            if (rhs) begin
                m_mem[rl][rb] = io_refill_data;
                m_bv[rl][rb]  = 1'b1;
                m_cnt[rl]     = (rb + 1) % NB;
            end
            if (io_alloc_valid) begin
                m_bv[int'(io_alloc_line)]  = '0;
                m_cnt[int'(io_alloc_line)] = 0;
            end
        end
    end

    initial begin
        int          acc;
        bit          got;
        logic [63:0] held;

        repeat (3) step();
        reset = 1'b1;

        // Alloc slot 0 and fill 8 beats 0x10..0x17.
        io_alloc_valid = 1'b1;
        io_alloc_line  = 1'b0;
        step();
        io_alloc_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            io_refill_valid = 1'b1;
            io_refill_line  = 1'b0;
            io_refill_data  = 64'h10 + 64'(i);
            step();
        end
        io_refill_valid = 1'b0;
        @(negedge clock);
        check("done_pulse", io_refill_done, 1);
        step();
        @(negedge clock);
        check("done_one_cycle", io_refill_done, 0);
        step();

        // Read slot 0 beat 3.
        io_resp_ready = 1'b1;
        io_req_valid  = 1'b1;
        io_req.line   = 1'b0;
        io_req.beat   = 3'd3;
        @(negedge clock);
        check("rd_ready", io_req_ready, 1);
        step();
        io_req_valid = 1'b0;
        @(negedge clock);
        check("rd_valid", io_resp_valid, 1);
        check("rd_data", io_resp_data, 64'h13);
        step();

        // Request slot 1 beat 5 before it exists, while slot 1 fills.
        io_alloc_valid = 1'b1;
        io_alloc_line  = 1'b1;
        step();
        io_alloc_valid = 1'b0;
        io_req_valid   = 1'b1;
        io_req.line    = 1'b1;
        io_req.beat    = 3'd5;
        acc = -1;
        for (int i = 0; i < NB; i++) begin
            io_refill_valid = 1'b1;
            io_refill_line  = 1'b1;
            io_refill_data  = 64'h20 + 64'(i);
            @(negedge clock);
            if (acc < 0 && io_req_ready) acc = i;
            step();
            if (acc >= 0) io_req_valid = 1'b0;
        end
        io_refill_valid = 1'b0;
        io_req_valid    = 1'b0;
        check("stall_until_beat5", 64'(acc), 64'd6);
        step();

        // Consumer stalls 4 cycles with a second request pending.
        io_resp_ready = 1'b0;
        io_req_valid  = 1'b1;
        io_req.line   = 1'b0;
        io_req.beat   = 3'd1;
        @(negedge clock);
        check("stall_first_acc", io_req_ready, 1);
        step();
        io_req.beat = 3'd2;
        held = 64'h11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("stall_hold_data", io_resp_data, held);
            check("stall_no_accept", io_req_ready, 0);
            step();
        end
        io_resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            io_req.line = (i % 2 == 0) ? 1'b0 : 1'b1;
            io_req.beat = 3'(2 + i);
            @(negedge clock);
            check("b2b_accept", io_req_ready, 1);
            check("b2b_valid", io_resp_valid, 1);
            step();
        end
        io_req_valid = 1'b0;
        step();

        // Alloc and refill hit slot 0 in the same cycle.
        io_alloc_valid  = 1'b1;
        io_alloc_line   = 1'b0;
        io_refill_valid = 1'b1;
        io_refill_line  = 1'b0;
        io_refill_data  = 64'hAA;
        @(negedge clock);
        check("coll_refill_ready", io_refill_ready, 0);
        step();
        io_alloc_valid = 1'b0;
        @(negedge clock);
        check("coll_ready_after", io_refill_ready, 1);
        step();
        io_refill_valid = 1'b0;
        io_req_valid    = 1'b1;
        io_req.line     = 1'b0;
        io_req.beat     = 3'd0;
        @(negedge clock);
        check("coll_beat0_ready", io_req_ready, 1);
        step();
        io_req.beat = 3'd1;
        @(negedge clock);
        check("coll_beat0_data", io_resp_data, 64'hAA);
        check("coll_beat1_cleared", io_req_ready, 0);
        step();
        io_req_valid = 1'b0;

        // Random reads, refills of slot 0 and consumer back-pressure.
        for (int i = 0; i < 80; i++) begin
            io_req_valid    = ($urandom_range(0, 1) == 1);
            io_req.line     = 1'($urandom_range(0, 1));
            io_req.beat     = 3'($urandom_range(0, 7));
            io_resp_ready   = ($urandom_range(0, 3) != 0);
            io_refill_valid = ($urandom_range(0, 3) == 0);
            io_refill_line  = 1'b0;
            io_refill_data  = {$urandom, $urandom};
            step();
        end
        io_req_valid    = 1'b0;
        io_refill_valid = 1'b0;
        io_resp_ready   = 1'b1;
        repeat (2) step();

        // Reset while a response is held.
        io_resp_ready = 1'b0;
        io_req_valid  = 1'b1;
        io_req.line   = 1'b1;
        io_req.beat   = 3'd2;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (io_req_ready) got = 1'b1;
            step();
        end
        check("pre_rst_accept", got, 1);
        io_req_valid = 1'b0;
        @(negedge clock);
        check("pre_rst_valid", io_resp_valid, 1);
        step();
        reset = 1'b0;
        step();
        @(negedge clock);
        check("rst_clears_valid", io_resp_valid, 0);
        step();
        reset         = 1'b1;
        io_resp_ready = 1'b1;
        io_req_valid  = 1'b1;
        io_req.line   = 1'b1;
        io_req.beat   = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_stall", io_req_ready, 0);
            check("post_rst_no_resp", io_resp_valid, 0);
            check("post_rst_no_done", io_refill_done, 0);
            step();
        end
        io_req_valid = 1'b0;
        repeat (3) step();
        check("sb_drained", 64'(m_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
